// File: rtl/multiway_traffic_ctrl.sv
// N-way traffic-light controller: demand-driven GREEN/YELLOW/ALLRED rotation with emergency
// preemption and night flashing; every state change waits for tick, lights decode registered state only.
module multiway_traffic_ctrl #(
  parameter int  NUM_DIR      = 4,
  parameter int  GREEN_TICKS  = 5,
  parameter int  YELLOW_TICKS = 2,
  parameter int  ALLRED_TICKS = 1,
  parameter int  CNT_W        = 8,
  localparam int DIR_W        = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic [NUM_DIR-1:0]   demand,
  input  logic                 preempt,
  input  logic [DIR_W-1:0]     preempt_dir,
  input  logic                 flash,
  output logic [3*NUM_DIR-1:0] lights,
  output logic [DIR_W-1:0]     active_dir,
  output logic [1:0]           phase
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10,
    ST_FLASH  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [DIR_W-1:0] LAST_DIR    = DIR_W'(NUM_DIR - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic             flash_on_q, flash_on_d;
  logic [DIR_W-1:0] pre_dir;
  logic [DIR_W-1:0] rr_dir;
  logic [DIR_W-1:0] idx;
  logic             found;

  assign pre_dir = (int'(preempt_dir) < NUM_DIR) ? preempt_dir : '0;

  // Search starts just after the current direction and visits it last.
  always_comb begin
    rr_dir = (dir_q == LAST_DIR) ? '0 : dir_q + 1'b1;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_DIR; i++) begin
      idx = DIR_W'((int'(dir_q) + i) % NUM_DIR);
      if (!found && demand[idx]) begin
        rr_dir = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    flash_on_d = flash_on_q;
    if (tick) begin
      case (state_q)
        ST_GREEN: begin
          if (preempt && (pre_dir != dir_q)) begin
            state_d = ST_YELLOW;
            cnt_d   = '0;
          end else if (preempt) begin
            cnt_d = '0;
          end else if (cnt_q == GREEN_LAST) begin
            state_d = ST_YELLOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_YELLOW: begin
          if (cnt_q == YELLOW_LAST) begin
            state_d = ST_ALLRED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_ALLRED: begin
          if (cnt_q == ALLRED_LAST) begin
            cnt_d = '0;
            if (preempt) begin
              state_d = ST_GREEN;
              dir_d   = pre_dir;
            end else if (flash) begin
              state_d    = ST_FLASH;
              flash_on_d = 1'b1;
            end else begin
              state_d = ST_GREEN;
              dir_d   = rr_dir;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          if (!flash || preempt) begin
            state_d = ST_ALLRED;
            cnt_d   = '0;
          end else begin
            flash_on_d = ~flash_on_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_ALLRED;
      cnt_q      <= '0;
      dir_q      <= LAST_DIR;
      flash_on_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      flash_on_q <= flash_on_d;
    end
  end

  always_comb begin
    lights = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      if (state_q == ST_FLASH)
        lights[3*d +: 3] = flash_on_q ? 3'b010 : 3'b000;
      else if ((DIR_W'(d) == dir_q) && (state_q == ST_GREEN))
        lights[3*d +: 3] = 3'b001;
      else if ((DIR_W'(d) == dir_q) && (state_q == ST_YELLOW))
        lights[3*d +: 3] = 3'b010;
      else
        lights[3*d +: 3] = 3'b100;
    end
  end

  assign active_dir = dir_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_multiway_traffic_ctrl.sv
// Scoreboard bench for multiway_traffic_ctrl at NUM_DIR=4, GREEN=5, YELLOW=2, ALLRED=1.
module tb_multiway_traffic_ctrl;

  localparam logic [1:0] PH_G = 2'b00;
  localparam logic [1:0] PH_Y = 2'b01;
  localparam logic [1:0] PH_A = 2'b10;
  localparam logic [1:0] PH_F = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [3:0]  demand;
  logic        preempt;
  logic [1:0]  preempt_dir;
  logic        flash;
  logic [11:0] lights;
  logic [1:0]  active_dir;
  logic [1:0]  phase;

  typedef struct packed {
    logic [1:0]  ph;
    logic [1:0]  dir;
    logic [11:0] lt;
  } exp_t;

  exp_t q[$];
  exp_t last;
  bit   div_mode = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  multiway_traffic_ctrl #(
    .NUM_DIR(4), .GREEN_TICKS(5), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .demand(demand),
    .preempt(preempt), .preempt_dir(preempt_dir), .flash(flash),
    .lights(lights), .active_dir(active_dir), .phase(phase)
  );

  function automatic logic [11:0] mk_lt(input logic [1:0] ph, input logic [1:0] dir, input bit on);
    logic [11:0] v;
    v = '0;
    for (int d = 0; d < 4; d++) begin
      if (ph == PH_F)                   v[3*d +: 3] = on ? 3'b010 : 3'b000;
      else if (d == dir && ph == PH_G)  v[3*d +: 3] = 3'b001;
      else if (d == dir && ph == PH_Y)  v[3*d +: 3] = 3'b010;
      else                              v[3*d +: 3] = 3'b100;
    end
    return v;
  endfunction

  // Queue n ticks of an expected observation; in divided-tick mode each tick is preceded by two held clocks.
  task automatic push(input logic [1:0] ph, input logic [1:0] dir, input int n, input bit on = 1'b1);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '{ph, dir, mk_lt(ph, dir, on)};
      if (div_mode) begin
        q.push_back(last);
        q.push_back(last);
      end
      q.push_back(e);
      last = e;
    end
  endtask

  task automatic clk_step(input logic t);
    tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] dm, input logic fl, input logic pe, input logic [1:0] pd);
    reset_n = 1'b0; tick = 1'b0;
    demand = dm; flash = fl; preempt = pe; preempt_dir = pd;
    q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    last = '{PH_A, 2'd3, 12'h924};
  endtask

  task automatic test_reset();
    reset_n = 1'b1; tick = 1'b1; demand = '0; flash = 1'b0; preempt = 1'b0; preempt_dir = '0;
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (phase !== PH_A) $display("FAIL reset_phase got %b want 10", phase); else n_pass++;
    n_chk++; if (active_dir !== 2'd3) $display("FAIL reset_dir got %0d want 3", active_dir); else n_pass++;
    n_chk++; if (lights !== 12'h924) $display("FAIL reset_lights got %h want 924", lights); else n_pass++;
    clk_step(1'b1);
    n_chk++;
    if ({phase, active_dir, lights} !== {PH_A, 2'd3, 12'h924})
      $display("FAIL reset_hold got ph=%b dir=%0d lights=%h want ph=10 dir=3 lights=924", phase, active_dir, lights);
    else n_pass++;
  endtask

  task automatic test_rotation();
    exp_t e;
    int   s = 0;
    do_reset(4'b0000, 1'b0, 1'b0, 2'd0);
    for (int r = 0; r < 5; r++) begin
      push(PH_G, 2'(r % 4), 5);
      push(PH_Y, 2'(r % 4), 2);
      push(PH_A, 2'(r % 4), 1);
    end
    while (q.size() != 0) begin
      clk_step(1'b1);
      e = q.pop_front(); n_chk++; s++;
      if ({phase, active_dir, lights} !== e)
        $display("FAIL rotation step %0d got ph=%b dir=%0d lights=%h want ph=%b dir=%0d lights=%h",
                 s, phase, active_dir, lights, e.ph, e.dir, e.lt);
      else n_pass++;
    end
  endtask

  task automatic test_demand();
    exp_t e;
    int   s = 0;
    do_reset(4'b1000, 1'b0, 1'b0, 2'd0);
    for (int r = 0; r < 2; r++) begin
      push(PH_G, 2'd3, 5); push(PH_Y, 2'd3, 2); push(PH_A, 2'd3, 1);
    end
    while (q.size() != 0) begin
      clk_step(1'b1);
      e = q.pop_front(); n_chk++; s++;
      if ({phase, active_dir, lights} !== e)
        $display("FAIL demand_single step %0d got ph=%b dir=%0d lights=%h want ph=%b dir=%0d lights=%h",
                 s, phase, active_dir, lights, e.ph, e.dir, e.lt);
      else n_pass++;
    end
    do_reset(4'b0101, 1'b0, 1'b0, 2'd0);
    s = 0;
    push(PH_G, 2'd0, 5); push(PH_Y, 2'd0, 2); push(PH_A, 2'd0, 1);
    push(PH_G, 2'd2, 5); push(PH_Y, 2'd2, 2); push(PH_A, 2'd2, 1);
    push(PH_G, 2'd0, 1);
    while (q.size() != 0) begin
      clk_step(1'b1);
      e = q.pop_front(); n_chk++; s++;
      if ({phase, active_dir, lights} !== e)
        $display("FAIL demand_skip step %0d got ph=%b dir=%0d lights=%h want ph=%b dir=%0d lights=%h",
                 s, phase, active_dir, lights, e.ph, e.dir, e.lt);
      else n_pass++;
    end
  endtask

  task automatic test_preempt();
    exp_t e;
    int   s = 0;
    do_reset(4'b0000, 1'b0, 1'b0, 2'd0);
    push(PH_G, 2'd0, 2);
    for (int seg = 0; seg < 3; seg++) begin
      while (q.size() != 0) begin
        clk_step(1'b1);
        e = q.pop_front(); n_chk++; s++;
        if ({phase, active_dir, lights} !== e)
          $display("FAIL preempt step %0d got ph=%b dir=%0d lights=%h want ph=%b dir=%0d lights=%h",
                   s, phase, active_dir, lights, e.ph, e.dir, e.lt);
        else n_pass++;
      end
      if (seg == 0) begin
        preempt = 1'b1; preempt_dir = 2'd2;
        push(PH_Y, 2'd0, 2); push(PH_A, 2'd0, 1); push(PH_G, 2'd2, 7);
      end else if (seg == 1) begin
        preempt = 1'b0;
        push(PH_G, 2'd2, 4); push(PH_Y, 2'd2, 2); push(PH_A, 2'd2, 1); push(PH_G, 2'd3, 1);
      end
    end
  endtask

  task automatic test_preempt_retarget();
    exp_t e;
    int   s = 0;
    do_reset(4'b0000, 1'b0, 1'b1, 2'd2);
    push(PH_G, 2'd2, 3);
    for (int seg = 0; seg < 3; seg++) begin
      while (q.size() != 0) begin
        clk_step(1'b1);
        e = q.pop_front(); n_chk++; s++;
        if ({phase, active_dir, lights} !== e)
          $display("FAIL preempt_retarget step %0d got ph=%b dir=%0d lights=%h want ph=%b dir=%0d lights=%h",
                   s, phase, active_dir, lights, e.ph, e.dir, e.lt);
        else n_pass++;
      end
      if (seg == 0) begin
        preempt_dir = 2'd1;
        push(PH_Y, 2'd2, 2); push(PH_A, 2'd2, 1); push(PH_G, 2'd1, 3);
      end else if (seg == 1) begin
        preempt = 1'b0;
        push(PH_G, 2'd1, 4); push(PH_Y, 2'd1, 1);
      end
    end
  endtask

  task automatic test_flash();
    exp_t e;
    int   s = 0;
    do_reset(4'b0000, 1'b1, 1'b0, 2'd0);
    push(PH_F, 2'd3, 1, 1'b1); push(PH_F, 2'd3, 1, 1'b0);
    push(PH_F, 2'd3, 1, 1'b1); push(PH_F, 2'd3, 1, 1'b0);
    for (int seg = 0; seg < 2; seg++) begin
      while (q.size() != 0) begin
        clk_step(1'b1);
        e = q.pop_front(); n_chk++; s++;
        if ({phase, active_dir, lights} !== e)
          $display("FAIL flash step %0d got ph=%b dir=%0d lights=%h want ph=%b dir=%0d lights=%h",
                   s, phase, active_dir, lights, e.ph, e.dir, e.lt);
        else n_pass++;
      end
      if (seg == 0) begin
        flash = 1'b0;
        push(PH_A, 2'd3, 1); push(PH_G, 2'd0, 2);
      end
    end
  endtask

  task automatic test_flash_preempt();
    exp_t e;
    int   s = 0;
    do_reset(4'b0000, 1'b1, 1'b0, 2'd0);
    push(PH_F, 2'd3, 1, 1'b1);
    for (int seg = 0; seg < 3; seg++) begin
      while (q.size() != 0) begin
        clk_step(1'b1);
        e = q.pop_front(); n_chk++; s++;
        if ({phase, active_dir, lights} !== e)
          $display("FAIL flash_preempt step %0d got ph=%b dir=%0d lights=%h want ph=%b dir=%0d lights=%h",
                   s, phase, active_dir, lights, e.ph, e.dir, e.lt);
        else n_pass++;
      end
      if (seg == 0) begin
        preempt = 1'b1; preempt_dir = 2'd1;
        push(PH_A, 2'd3, 1); push(PH_G, 2'd1, 4);
      end else if (seg == 1) begin
        preempt = 1'b0;
        push(PH_G, 2'd1, 4); push(PH_Y, 2'd1, 2); push(PH_A, 2'd1, 1); push(PH_F, 2'd1, 1, 1'b1);
      end
    end
  endtask

  task automatic test_tick_div();
    exp_t e;
    int   k = 0;
    do_reset(4'b0000, 1'b0, 1'b0, 2'd0);
    div_mode = 1'b1;
    push(PH_G, 2'd0, 5); push(PH_Y, 2'd0, 1);
    while (q.size() != 0) begin
      clk_step(k % 3 == 2);
      k++;
      e = q.pop_front(); n_chk++;
      if ({phase, active_dir, lights} !== e)
        $display("FAIL tick_div clk %0d got ph=%b dir=%0d lights=%h want ph=%b dir=%0d lights=%h",
                 k, phase, active_dir, lights, e.ph, e.dir, e.lt);
      else n_pass++;
    end
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (phase !== PH_A) $display("FAIL midyellow_reset_phase got %b want 10", phase); else n_pass++;
    n_chk++; if (active_dir !== 2'd3) $display("FAIL midyellow_reset_dir got %0d want 3", active_dir); else n_pass++;
    n_chk++; if (lights !== 12'h924) $display("FAIL midyellow_reset_lights got %h want 924", lights); else n_pass++;
    clk_step(1'b1);
    reset_n = 1'b1;
    last = '{PH_A, 2'd3, 12'h924};
    k = 0;
    push(PH_G, 2'd0, 5); push(PH_Y, 2'd0, 2); push(PH_A, 2'd0, 1); push(PH_G, 2'd1, 1);
    while (q.size() != 0) begin
      clk_step(k % 3 == 2);
      k++;
      e = q.pop_front(); n_chk++;
      if ({phase, active_dir, lights} !== e)
        $display("FAIL tick_div_restart clk %0d got ph=%b dir=%0d lights=%h want ph=%b dir=%0d lights=%h",
                 k, phase, active_dir, lights, e.ph, e.dir, e.lt);
      else n_pass++;
    end
    div_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_demand();
    test_preempt();
    test_preempt_retarget();
    test_flash();
    test_flash_preempt();
    test_tick_div();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multiway_traffic_ctrl.md
MULTIWAY_TRAFFIC_CTRL -- requirements
Module: multiway_traffic_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIR, default 4, meaning the number of approach directions, legal range 2..8.
REQ-002 The block SHALL have parameter GREEN_TICKS, default 5, meaning green duration in ticks, minimum 1.
REQ-003 The block SHALL have parameter YELLOW_TICKS, default 2, meaning yellow duration in ticks, minimum 1.
REQ-004 The block SHALL have parameter ALLRED_TICKS, default 1, meaning all-red clearance duration in ticks, minimum 1.
REQ-005 The block SHALL have parameter CNT_W, default 8, meaning timer width; it must hold max(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS) - 1.
REQ-006 The block SHALL have localparam DIR_W = max(1, clog2(NUM_DIR)).
REQ-007 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port reset_n, input, width 1: asynchronous, active-low reset.
REQ-009 The block SHALL have port tick, input, width 1: one-cycle timebase enable; all timing and state advances occur only on cycles with tick=1.
REQ-010 The block SHALL have port demand, input, width NUM_DIR: per-direction vehicle-present levels.
REQ-011 The block SHALL have port preempt, input, width 1: emergency preemption request level.
REQ-012 The block SHALL have port preempt_dir, input, width DIR_W: the direction to serve during preemption; out-of-range values map to direction 0.
REQ-013 The block SHALL have port flash, input, width 1: night flashing-mode request level.
REQ-014 The block SHALL have port lights, output, width 3*NUM_DIR: per direction d, bits [3d+2:3d] = {red, yellow, green}; red=100, yellow=010, green=001, dark=000.
REQ-015 The block SHALL have port active_dir, output, width DIR_W: the direction currently or most recently served.
REQ-016 The block SHALL have port phase, output, width 2: 00 GREEN, 01 YELLOW, 10 ALLRED, 11 FLASH.

Function
REQ-017 The block SHALL implement states GREEN, YELLOW, ALLRED and FLASH, with a tick counter cleared to 0 on every state entry.
REQ-018 In a timed state of duration D, on a tick with count < D-1 the block SHALL increment count; on a tick with count = D-1 it SHALL take the transition and clear count, so each state lasts exactly D ticks.
REQ-019 Timed transitions SHALL be GREEN->YELLOW->ALLRED->GREEN.
REQ-020 At ALLRED expiry, the next active_dir SHALL be the first direction after active_dir, searching cyclically with wrap-around and including active_dir last, whose demand bit is set; if demand is all zero, next = (active_dir+1) mod NUM_DIR.
REQ-021 In GREEN, lights[active_dir] SHALL be 001; in YELLOW it SHALL be 010; all other directions, and all directions in ALLRED, SHALL be 100.
REQ-022 Preemption, on a tick with preempt=1:
- GREEN on another direction: go to YELLOW immediately, count cleared.
- YELLOW: continue its timed expiry.
- ALLRED expiry: next direction = preempt_dir, overriding demand.
REQ-023 While preempt=1 and the state is GREEN on preempt_dir, the block SHALL hold GREEN with count held at 0; when preempt falls, the full GREEN_TICKS then elapse.
REQ-024 A change of preempt_dir during a preemption hold SHALL be treated as preemption against a different direction, per REQ-022.
REQ-025 If flash=1 and preempt=0 at ALLRED expiry, the block SHALL enter FLASH instead of GREEN; flash is ignored in all other states.
REQ-026 In FLASH, all directions SHALL show 010 and 000 alternately, toggling on every tick, starting with 010 on entry.
REQ-027 In FLASH, on a tick with flash=0 or preempt=1, the block SHALL go to ALLRED, with active_dir unchanged.
REQ-028 Preempt SHALL take priority over flash whenever both are asserted.
REQ-029 On cycles with tick=0, all state, counter, active_dir and outputs SHALL hold.
REQ-030 The outputs SHALL be registered or decoded purely from registered state; no input SHALL combinationally affect lights.

Reset
REQ-031 On reset_n=0, at any time including mid-phase, the block SHALL immediately set state=ALLRED, count=0, active_dir=NUM_DIR-1, flash toggle=on, lights all 100 and phase=10.
REQ-032 After reset release with tick=1 and demand=0, the first GREEN SHALL be on direction 0 after ALLRED_TICKS ticks.

Verification (NUM_DIR=4, GREEN=5, YELLOW=2, ALLRED=1, tick=1 each cycle unless stated)
REQ-033 Reset release, demand=0 -> green sequence over directions 0,1,2,3,0, each cycle of 5 GREEN, 2 YELLOW, 1 ALLRED = 8 cycles per direction.
REQ-034 demand=4'b1000 constant -> direction 3 only receives green, repeatedly, with YELLOW/ALLRED between; demand=4'b0101 with active_dir=0 -> next green goes to 2.
REQ-035 preempt=1, preempt_dir=2 at GREEN count 1 on direction 0 -> YELLOW 2 ticks, ALLRED 1 tick, GREEN dir 2 held while preempt=1; after preempt drops, 5 more GREEN ticks.
REQ-036 flash=1 before ALLRED expiry -> FLASH, lights alternate 0x492 and 0x000 each tick; flash=0 -> ALLRED 1 tick, then GREEN on next direction.
REQ-037 tick asserted every 3rd cycle -> every phase duration is tripled in clocks; reset_n pulsed low mid-YELLOW -> all red immediately, with the REQ-032 restart sequence.
